// File: rtl/open_list_queue_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | open_list_queue_driver_if : push/pop valid-ready streams of driver    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface open_list_queue_driver_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_push_valid;
  logic                  s_push_ready;
  logic [DATA_WIDTH-1:0] s_push_data;
  logic                  m_pop_valid;
  logic                  m_pop_ready;
  logic [DATA_WIDTH-1:0] m_pop_data;

  modport slave (
    input  s_push_valid, s_push_data, m_pop_ready,
    output s_push_ready, m_pop_valid, m_pop_data
  );

  modport master (
    output s_push_valid, s_push_data, m_pop_ready,
    input  s_push_ready, m_pop_valid, m_pop_data
  );
endinterface
`default_nettype wire

// File: rtl/open_list_queue_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | open_list_queue_driver : stream front end for systolic min queue      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module open_list_queue_driver #(
  parameter int DATA_WIDTH    = 32,
  parameter int QUEUE_SIZE    = 2048,
  parameter int SETTLE_CYCLES = 2
) (
  input  wire                           CLK,
  input  wire                           RST,
  open_list_queue_driver_if.slave       bus,
  input  wire                           i_flush,
  output logic                          o_flush_done,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_node_f,
  input  wire                           i_q_full,
  input  wire                           i_q_empty,
  input  wire  [DATA_WIDTH-1:0]         i_q_node_f,
  output logic [$clog2(2*QUEUE_SIZE):0] o_count,
  output logic                          o_err
);

  localparam int CNT_W = $clog2(2*QUEUE_SIZE) + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(2*QUEUE_SIZE);
  localparam logic [SET_W-1:0] C_SET_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] C_SET_ONE  = SET_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t           state_q;
  logic [SET_W-1:0] settle_q;
  logic [CNT_W-1:0] count_q;
  logic             flushing_q;
  logic             err_q;
  logic             flush_done_q;

  logic w_open;
  logic w_push_fire;
  logic w_pop_fire;
  logic w_flush_rd;
  logic w_cnt_full;
  logic w_status_bad;

  // Nothing is issued while reset is asserted, even if the state reads IDLE.
  assign w_open       = (state_q == S_IDLE) && !i_flush && !RST;
  assign bus.s_push_ready = w_open && !i_q_full;
  assign bus.m_pop_valid  = w_open && !i_q_empty;
  assign bus.m_pop_data   = i_q_node_f;

  assign w_push_fire = bus.s_push_valid && bus.s_push_ready;
  assign w_pop_fire  = bus.m_pop_valid && bus.m_pop_ready;
  assign w_flush_rd  = (state_q == S_FLUSH) && (settle_q == '0) &&
                       (count_q != '0) && !RST;

  assign o_q_wrt    = w_push_fire;
  assign o_q_read   = w_pop_fire || w_flush_rd;
  assign o_q_node_f = w_push_fire ? bus.s_push_data : '0;

  assign w_cnt_full   = (count_q == C_CNT_FULL);
  assign w_status_bad = ((count_q == '0) != i_q_empty) || (w_cnt_full != i_q_full);

  assign o_count      = count_q;
  assign o_err        = err_q;
  assign o_flush_done = flush_done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      count_q      <= '0;
      flushing_q   <= 1'b0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if ((state_q == S_IDLE) && (settle_q == '0) && w_status_bad) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (w_push_fire || w_pop_fire) begin
            state_q    <= S_SETTLE;
            settle_q   <= C_SET_LOAD;
            flushing_q <= 1'b0;
            if (w_push_fire && !w_pop_fire) begin
              count_q <= count_q + C_CNT_ONE;
            end else if (w_pop_fire && !w_push_fire) begin
              count_q <= count_q - C_CNT_ONE;
            end
          end else if (i_flush) begin
            if (count_q == '0) begin
              flush_done_q <= 1'b1;
            end else begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q - C_SET_ONE;
          if (settle_q <= C_SET_ONE) begin
            settle_q <= '0;
            state_q  <= flushing_q ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          // Drained entries are discarded; the settle gap still applies between reads.
          if (count_q != '0) begin
            count_q    <= count_q - C_CNT_ONE;
            settle_q   <= C_SET_LOAD;
            flushing_q <= 1'b1;
            state_q    <= S_SETTLE;
          end else begin
            flush_done_q <= 1'b1;
            flushing_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
